// File: rtl/johnson_seq_monitor_if.sv
// Interface bundling the Johnson monitor's sample input and status outputs.
// master: the side that supplies samples and observes status.
// slave:  the monitor itself.
interface johnson_seq_monitor_if #(
    parameter int unsigned CYC_W = 8,
    parameter int unsigned ERR_W = 4
);
    logic             in_valid;
    logic [3:0]       in_code;
    logic [2:0]       phase;
    logic [7:0]       phase_oh;
    logic             locked;
    logic             wrap_pulse;
    logic [CYC_W-1:0] cycle_cnt;
    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, in_code,
        input  phase, phase_oh, locked, wrap_pulse, cycle_cnt, err_pulse, err_sticky, err_cnt
    );

    modport slave (
        input  in_valid, in_code,
        output phase, phase_oh, locked, wrap_pulse, cycle_cnt, err_pulse, err_sticky, err_cnt
    );
endinterface

// File: rtl/johnson_seq_monitor.sv
// Johnson counter sequence monitor: decodes sampled 4-bit Johnson codes to a phase,
// checks each step against the legal successor, counts revolutions and errors.
// Optional macro JOHNSON_MON_RESYNC_EN: on a TRACK error, resynchronise (legal code)
// or fall back to IDLE (illegal code) instead of parking in the terminal ERR state.
module johnson_seq_monitor #(
    parameter int unsigned CYC_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input logic                  clk,
    input logic                  reset,
    johnson_seq_monitor_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StTrack, StErr} state_e;

    state_e           state_q;
    logic [2:0]       phase_q;
    logic             locked_q;
    logic             wrap_q;
    logic [CYC_W-1:0] cycle_cnt_q;
    logic             err_q;
    logic             sticky_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             dec_legal;
    logic [2:0]       dec_phase;
    logic [3:0]       cur_code;
    logic [3:0]       exp_code;
    logic             is_expected;
    logic             is_hold;
    logic             err_event;

    function automatic logic [3:0] phase_to_code(input logic [2:0] p);
        logic [3:0] c;
        case (p)
            3'd0:    c = 4'h0;
            3'd1:    c = 4'h1;
            3'd2:    c = 4'h3;
            3'd3:    c = 4'h7;
            3'd4:    c = 4'hF;
            3'd5:    c = 4'hE;
            3'd6:    c = 4'hC;
            default: c = 4'h8;
        endcase
        return c;
    endfunction

    // Decode the sampled code and classify it against the current phase.
    always_comb begin
        dec_legal = 1'b1;
        dec_phase = 3'd0;
        case (bus.in_code)
            4'h0:    dec_phase = 3'd0;
            4'h1:    dec_phase = 3'd1;
            4'h3:    dec_phase = 3'd2;
            4'h7:    dec_phase = 3'd3;
            4'hF:    dec_phase = 3'd4;
            4'hE:    dec_phase = 3'd5;
            4'hC:    dec_phase = 3'd6;
            4'h8:    dec_phase = 3'd7;
            default: dec_legal = 1'b0;
        endcase
        cur_code    = phase_to_code(phase_q);
        exp_code    = phase_to_code(phase_q + 3'd1);
        is_expected = (bus.in_code == exp_code);
        // A repeated code means the counter runs slower than us; not an error.
        is_hold     = (bus.in_code == cur_code);
        err_event   = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                StIdle:  err_event = !dec_legal;
                StTrack: err_event = !is_expected && !is_hold;
                default: err_event = 1'b0;
            endcase
        end
    end

    // Tracking FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_q     <= 3'd0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            cycle_cnt_q <= '0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (err_event) begin
                err_q    <= 1'b1;
                sticky_q <= 1'b1;
                if (err_cnt_q != {ERR_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
            end
            if (bus.in_valid) begin
                unique case (state_q)
                    StIdle: begin
                        // Entry never counts a wrap, even when locking on code 0.
                        if (dec_legal) begin
                            state_q  <= StTrack;
                            phase_q  <= dec_phase;
                            locked_q <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (is_expected) begin
                            phase_q <= phase_q + 3'd1;
                            if (phase_q == 3'd7) begin
                                wrap_q      <= 1'b1;
                                cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
                            end
                        end else if (!is_hold) begin
`ifdef JOHNSON_MON_RESYNC_EN
                            if (dec_legal) begin
                                phase_q <= dec_phase;
                            end else begin
                                state_q  <= StIdle;
                                locked_q <= 1'b0;
                            end
`else
                            state_q  <= StErr;
                            locked_q <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        // ERR is terminal until reset.
                    end
                endcase
            end
        end
    end

    // One-hot phase follows the registered phase, gated by lock.
    always_comb begin
        bus.phase_oh = 8'h00;
        if (locked_q) begin
            bus.phase_oh = 8'h01 << phase_q;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.locked     = locked_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.err_pulse  = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Self-checking bench for johnson_seq_monitor: table vectors, hand-written corner
// sequences and randomized stimulus against a sequence-position reference model.
module tb_johnson_seq_monitor;

    localparam int CYC_W = 8;
    localparam int ERR_W = 4;

    logic clk = 1'b0;
    logic reset;

    johnson_seq_monitor_if #(.CYC_W(CYC_W), .ERR_W(ERR_W)) bus ();

    johnson_seq_monitor #(.CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // The Johnson sequence by position; the model finds codes by searching it.
    logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // Reference model: 0 = unlocked, 1 = tracking, 2 = dead (terminal).
    int m_state, m_phase, m_cyc, m_ec;
    bit m_sticky, m_wrap, m_errp;

    typedef struct {
        bit         rst;
        bit         vld;
        logic [3:0] code;
        int         ph;
        bit         lk;
        bit         wr;
        int         cyc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find_idx(input logic [3:0] code);
        for (int i = 0; i < 8; i++) begin
            if (seq[i] == code) return i;
        end
        return -1;
    endfunction

    function automatic void model_err();
        m_errp   = 1'b1;
        m_sticky = 1'b1;
        if (m_ec < (1 << ERR_W) - 1) m_ec++;
    endfunction

    function automatic void model_update(input bit rst, input bit vld, input logic [3:0] code);
        int idx;
        idx    = find_idx(code);
        m_wrap = 1'b0;
        m_errp = 1'b0;
        if (rst) begin
            m_state = 0; m_phase = 0; m_cyc = 0; m_ec = 0; m_sticky = 1'b0;
        end else if (vld) begin
            if (m_state == 0) begin
                if (idx >= 0) begin
                    m_state = 1;
                    m_phase = idx;
                end else begin
                    model_err();
                end
            end else if (m_state == 1) begin
                if (idx == (m_phase + 1) % 8) begin
                    if (m_phase == 7) begin
                        m_wrap = 1'b1;
                        m_cyc  = (m_cyc + 1) % (1 << CYC_W);
                    end
                    m_phase = idx;
                end else if (idx != m_phase) begin
                    model_err();
`ifdef JOHNSON_MON_RESYNC_EN
                    if (idx >= 0) m_phase = idx;
                    else m_state = 0;
`else
                    m_state = 2;
`endif
                end
            end
        end
    endfunction

    task automatic drive_edge(input bit rst, input bit vld, input logic [3:0] code);
        reset        = rst;
        bus.in_valid = vld;
        bus.in_code  = code;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle and compare every output with the model.
    task automatic mstep(input bit rst, input bit vld, input logic [3:0] code);
        int lk;
        model_update(rst, vld, code);
        drive_edge(rst, vld, code);
        lk = (m_state == 1) ? 1 : 0;
        chk("locked",     int'(bus.locked),     lk);
        chk("phase",      int'(bus.phase),      m_phase);
        chk("phase_oh",   int'(bus.phase_oh),   lk != 0 ? (1 << m_phase) : 0);
        chk("wrap_pulse", int'(bus.wrap_pulse), int'(m_wrap));
        chk("cycle_cnt",  int'(bus.cycle_cnt),  m_cyc);
        chk("err_pulse",  int'(bus.err_pulse),  int'(m_errp));
        chk("err_sticky", int'(bus.err_sticky), int'(m_sticky));
        chk("err_cnt",    int'(bus.err_cnt),    m_ec);
    endtask

    function automatic vec_t mk(input bit rst, input bit vld, input logic [3:0] code,
                                input int ph, input bit lk, input bit wr, input int cyc);
        vec_t v;
        v.rst = rst; v.vld = vld; v.code = code;
        v.ph = ph; v.lk = lk; v.wr = wr; v.cyc = cyc;
        return v;
    endfunction

    initial begin
        int r;
        int cur;
        logic [3:0] c;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = 4'h0;

        // Clean run: two revolutions, then reset mid-run, relock, stall pattern.
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
        for (int rev = 0; rev < 2; rev++) begin
            for (int i = 0; i < 8; i++) begin
                tbl.push_back(mk(0, 1, seq[i], i, 1, (rev == 1 && i == 0), rev));
            end
        end
        tbl.push_back(mk(0, 1, 4'h0, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 2));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 1, seq[i], i, 1, 0, 2));
        tbl.push_back(mk(1, 1, 4'hC, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'hC, 6, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 2, 1, 0, 0));

        foreach (tbl[k]) begin
            drive_edge(tbl[k].rst, tbl[k].vld, tbl[k].code);
            chk($sformatf("tbl%0d_locked", k), int'(bus.locked), int'(tbl[k].lk));
            chk($sformatf("tbl%0d_phase", k), int'(bus.phase), tbl[k].ph);
            chk($sformatf("tbl%0d_phase_oh", k), int'(bus.phase_oh),
                tbl[k].lk ? (1 << tbl[k].ph) : 0);
            chk($sformatf("tbl%0d_wrap", k), int'(bus.wrap_pulse), int'(tbl[k].wr));
            chk($sformatf("tbl%0d_cyc", k), int'(bus.cycle_cnt), tbl[k].cyc);
            chk($sformatf("tbl%0d_err", k), int'(bus.err_pulse), 0);
            chk($sformatf("tbl%0d_errcnt", k), int'(bus.err_cnt), 0);
        end

        // Skip error: 0,1,7.
        mstep(1, 0, 4'h0);
        mstep(0, 1, 4'h0);
        mstep(0, 1, 4'h1);
        mstep(0, 1, 4'h7);
        chk("skip_err_pulse", int'(bus.err_pulse), 1);
        chk("skip_sticky", int'(bus.err_sticky), 1);
        chk("skip_err_cnt", int'(bus.err_cnt), 1);
`ifdef JOHNSON_MON_RESYNC_EN
        chk("skip_phase", int'(bus.phase), 3);
        chk("skip_locked", int'(bus.locked), 1);
        mstep(0, 1, 4'hF);
        chk("skip_resync_phase", int'(bus.phase), 4);
        chk("skip_resync_err", int'(bus.err_pulse), 0);
`else
        chk("skip_locked", int'(bus.locked), 0);
        chk("skip_phase_hold", int'(bus.phase), 1);
        mstep(0, 1, 4'hF);
        mstep(0, 1, 4'h0);
        chk("dead_locked", int'(bus.locked), 0);
        chk("dead_err_cnt", int'(bus.err_cnt), 1);
`endif

        // Illegal code from IDLE and from TRACK.
        mstep(1, 0, 4'h0);
        mstep(0, 1, 4'h5);
        chk("ill_idle_err", int'(bus.err_pulse), 1);
        chk("ill_idle_locked", int'(bus.locked), 0);
        mstep(0, 1, 4'h0);
        chk("ill_relock", int'(bus.locked), 1);
        mstep(0, 1, 4'h5);
        chk("ill_track_err", int'(bus.err_pulse), 1);
        chk("ill_track_cnt", int'(bus.err_cnt), 2);
        chk("ill_track_locked", int'(bus.locked), 0);
        mstep(0, 1, 4'h3);
`ifdef JOHNSON_MON_RESYNC_EN
        chk("ill_back_to_idle_relock", int'(bus.locked), 1);
`else
        chk("ill_dead_ignores", int'(bus.locked), 0);
`endif

        // Error counter saturation: 20 back-to-back illegal samples from IDLE.
        mstep(1, 0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            mstep(0, 1, 4'h5);
            chk($sformatf("sat%0d_pulse", i), int'(bus.err_pulse), 1);
        end
        chk("sat_cnt", int'(bus.err_cnt), 15);

        // Revolution counter wraps to zero after 256 revolutions.
        mstep(1, 0, 4'h0);
        mstep(0, 1, 4'h0);
        for (int rev = 0; rev < 256; rev++) begin
            for (int i = 1; i <= 8; i++) mstep(0, 1, seq[i % 8]);
        end
        chk("cyc_wrap_cnt", int'(bus.cycle_cnt), 0);
        chk("cyc_wrap_pulse", int'(bus.wrap_pulse), 1);
        chk("cyc_wrap_no_err", int'(bus.err_cnt), 0);

        // Randomized stimulus against the model.
        mstep(1, 0, 4'h0);
        cur = 7;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                cur = (cur + 1) % 8;
                mstep(0, 1, seq[cur]);
            end else if (r < 75) begin
                mstep(0, 1, seq[cur]);
            end else if (r < 86) begin
                c = 4'($urandom_range(0, 15));
                mstep(0, 0, c);
            end else if (r < 97) begin
                c = 4'($urandom_range(0, 15));
                mstep(0, 1, c);
            end else begin
                c = 4'($urandom_range(0, 15));
                mstep(1, $urandom_range(0, 1) != 0, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/johnson_seq_monitor.md
# johnson_seq_monitor

Downstream checker for the 4-bit Johnson counter (sequence 0,1,3,7,F,E,C,8). It samples the counter's `q[3:0]` on each valid strobe and decodes it to a phase index and a one-hot phase. It also checks every step against the legal Johnson successor, counts completed 8-state revolutions, and flags and counts sequence errors. Its outputs drive phase-selected logic and the status/debug registers.

## Interface
Parameters:
- `CYC_W`, default 8: width of the revolution counter.
- `ERR_W`, default 4: width of the saturating error counter.

Ports:
- `clk`, input, 1: clock, rising-edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: `in_code` is sampled this cycle.
- `in_code`, input, 4: Johnson counter output `q[3:0]`.
- `phase`, output, 3: decoded phase index 0–7.
- `phase_oh`, output, 8: `1 << phase` when `locked`, otherwise 0.
- `locked`, output, 1: monitor is tracking a legal sequence.
- `wrap_pulse`, output, 1: one-cycle pulse on the phase 7→0 step.
- `cycle_cnt`, output, `CYC_W`: completed revolutions, wraps modulo 2^`CYC_W`.
- `err_pulse`, output, 1: one-cycle pulse per detected error.
- `err_sticky`, output, 1: set on any error, cleared only by reset.
- `err_cnt`, output, `ERR_W`: error count, saturates at all-ones.

## Operation
Decode table (code → phase):
- 0x0→0, 0x1→1, 0x3→2, 0x7→3, 0xF→4, 0xE→5, 0xC→6, 0x8→7.
- The other 8 codes are illegal.

The expected code is the code for `(phase+1) mod 8`.

FSM states: IDLE, TRACK, ERR. Reset state is IDLE.
- **IDLE:** `locked`=0.
  - Valid legal code → TRACK, `phase`=decoded value, `locked`=1. No wrap is counted on entry, even for code 0x0.
  - Valid illegal code → error event; stay in IDLE.
- **TRACK:**
  - Valid expected code → `phase` advances. If the step is 7→0, assert `wrap_pulse` and increment `cycle_cnt`.
  - Valid code equal to the current phase's code → hold; no error, no change. This covers a counter clocked slower than the monitor.
  - Any other valid code → error event. The next state is defined under Configuration.
- **ERR** (only without the macro): `locked`=0 and `phase` holds its last value. All inputs are ignored until reset.
- **Error event:**
  - `err_pulse`=1 for one cycle.
  - `err_sticky`=1.
  - `err_cnt` += 1 unless it is already all-ones.
- Cycles with `in_valid`=0: no state change, and all pulses are 0.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N, i.e. 1-cycle latency.
- `wrap_pulse` and `err_pulse` are high for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- `phase_oh` is derived from the registered `phase` and `locked`, and is consistent with them in the same cycle.
- `reset` dominates `in_valid`. Reset asserted mid-sequence clears all state at the next edge.
- Reset values:
  - `phase`=0, `phase_oh`=0, `locked`=0.
  - `wrap_pulse`=0, `err_pulse`=0, `err_sticky`=0.
  - `cycle_cnt`=0, `err_cnt`=0.
  - FSM=IDLE.
- `cycle_cnt` all-ones + wrap → 0. No other flag is raised.
- `err_cnt` at all-ones + error → stays at all-ones; `err_pulse` still fires.

## Configuration
Macro `JOHNSON_MON_RESYNC_EN`.

- **Defined** (ERR state unused): on an error in TRACK:
  - Legal but unexpected code → stay in TRACK, `phase`=decoded value, `locked` stays 1, no wrap counted.
  - Illegal code → IDLE, `locked`=0.
- **Undefined:** any error in TRACK → ERR, which is terminal until reset.

Error reporting (`err_pulse`, `err_sticky`, `err_cnt`) is identical in both builds.

## Test plan
- **Clean run:** reset, then 17 valid samples 0,1,3,7,F,E,C,8,0,…,0.
  - `locked`=1 one cycle after the first sample.
  - `phase` steps 0..7.
  - `wrap_pulse` fires twice; `cycle_cnt`=2; `err_cnt`=0.
- **Repeat/stall:** codes 0,1,1,1,3 with `in_valid` toggling.
  - `phase` goes 0,1,1,1,2.
  - No `err_pulse`.
- **Skip error:** codes 0,1,7.
  - `err_pulse` once; `err_sticky`=1; `err_cnt`=1.
  - Without the macro: `locked`=0 and later valid codes are ignored.
  - With the macro: `phase`=3 and `locked`=1, then code F advances to phase 4 with no error.
- **Illegal code:** code 0x5 from IDLE and from TRACK.
  - Error counted in both cases.
  - With the macro, TRACK → IDLE.
  - `err_cnt` saturates at 15 after 20 illegal samples (with the macro).
- **Reset mid-run:** assert `reset` at phase 5 together with `in_valid`.
  - Next cycle all outputs are at their reset values.
  - Relock on a code of C gives `phase`=6 with no wrap.
